adc_line_sequencer: RTL and testbench
=====================================

Name: adc_line_sequencer

Overview:
- Sits directly upstream of the ping-pong line buffer.
- Issues per-pixel ADC conversion strobes for one detector channel and realigns the pipelined ADC result to its conversion.
- Drives the buffer's write data, write enable and bank-select signals.
- Counts pixels per line and lines per frame; flags line and frame completion to the frame controller.

Parameters:
- ADC_WIDTH, 14, ADC sample width; equals buffer data width.
- PIX_PER_LINE, 320, pixels per line for this channel (PIX_IN_ROW/NUMB_CHAN).
- ROWS, 240, lines per frame.
- ADC_LATENCY, 3, cycles from ADC_CONVST high to matching ADC_DATA valid; range 1..15.
- LINE_BLANK, 16, idle cycles between lines; range 1..255.

Ports:
- CLK  in  1  single system clock; everything on rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- FRAME_START  in  1  one-cycle request to start a frame; honoured only in IDLE.
- ADC_DATA  in  ADC_WIDTH  ADC conversion result.
- ADC_CONVST  out  1  conversion strobe, one pixel per high cycle.
- DATA_OUT  out  ADC_WIDTH  sample to line buffer (DATA_IN).
- BUFER_IN_EN  out  1  DATA_OUT valid; write enable.
- BUFER_CHANGE  out  1  bank select; toggles at each line end.
- LINE_DONE  out  1  one-cycle pulse after the last write of a line.
- FRAME_DONE  out  1  one-cycle pulse coincident with the last LINE_DONE of a frame.
- BUSY  out  1  high whenever not IDLE.
- ROW_CNT  out  clog2(ROWS)  index of the line currently being acquired.

Behaviour:
- Reset (RESET_N low at an edge): state IDLE; all outputs 0, including BUFER_CHANGE, DATA_OUT and ROW_CNT. The valid pipe and counters clear. Reset mid-line discards the line: no LINE_DONE and no toggle.
- All outputs are registered.
- States: IDLE, LINE, FLUSH, BLANK.
- Cycle numbering: cycle 0 is the cycle FRAME_START is sampled high in IDLE.
- IDLE: FRAME_START=1 -> LINE at cycle 1; ROW_CNT=0.
- LINE: ADC_CONVST=1 for exactly PIX_PER_LINE consecutive cycles, then -> FLUSH.
- Valid pipe: a shift register ADC_LATENCY deep tracks conversions.
  - Conversion issued in cycle t: ADC_DATA is sampled at the end of cycle t+ADC_LATENCY.
  - DATA_OUT holds that value and BUFER_IN_EN=1 during cycle t+ADC_LATENCY+1.
  - DATA_OUT holds its last value when BUFER_IN_EN=0.
- FLUSH: waits until the last sample has been presented. In the cycle after the last BUFER_IN_EN:
  - LINE_DONE=1 and BUFER_CHANGE inverts (same cycle).
  - If ROW_CNT==ROWS-1: FRAME_DONE=1 in that same cycle, no blanking; IDLE next cycle, BUSY low.
  - Otherwise -> BLANK in that cycle; ROW_CNT increments.
- BLANK: lasts LINE_BLANK cycles, the LINE_DONE cycle counting as the first; then -> LINE.
- BUFER_CHANGE is never forced at frame start. It toggles once per completed line across frames, so an odd ROWS alternates the starting bank per frame.
- FRAME_START outside IDLE is ignored, with no queuing. FRAME_START in the cycle BUSY falls (the first IDLE cycle) is accepted.
- Exactly PIX_PER_LINE BUFER_IN_EN pulses per line, never more. No sample is written during BLANK or IDLE.
- ADC_DATA is ignored except at the pipe tap.

Test Plan:
- Reset:
  - Stimulus: RESET_N low 3 cycles with FRAME_START=1 and ADC_DATA=14'h3FFF.
  - Required: all outputs 0 throughout; still IDLE after release until a new FRAME_START.
- Latency and data alignment:
  - Stimulus: PIX_PER_LINE=4, ADC_LATENCY=2, LINE_BLANK=3, ROWS=2; FRAME_START at cycle 0; ADC model returns 100+k for the k-th conversion.
  - Required:
    - ADC_CONVST high cycles 1-4.
    - BUFER_IN_EN high cycles 4-7, DATA_OUT=100,101,102,103.
    - LINE_DONE cycle 8 with BUFER_CHANGE 0->1.
    - ADC_CONVST high cycles 11-14.
    - LINE_DONE+FRAME_DONE cycle 18, BUFER_CHANGE 1->0.
    - BUSY low cycle 19.
- Back-to-back frames:
  - Stimulus: same setup; FRAME_START at cycle 19.
  - Required: ADC_CONVST high cycles 20-23; ROW_CNT=0 at cycle 20.
- Ignored start:
  - Stimulus: FRAME_START pulses at cycles 2, 9 and 15 of the first frame.
  - Required: timing identical to the latency/data-alignment scenario; exactly 8 BUFER_IN_EN pulses; a single FRAME_DONE.
- Reset mid-line:
  - Stimulus: RESET_N low at cycle 13.
  - Required: BUFER_IN_EN=0 and BUFER_CHANGE=0 from cycle 14; no LINE_DONE; ROW_CNT=0.
- Parameter corner:
  - Stimulus: ADC_LATENCY=1, LINE_BLANK=1, PIX_PER_LINE=1, ROWS=3.
  - Required: 3 writes total; LINE_DONE at cycles 4, 8 and 12; the cycle-12 pulse has FRAME_DONE; BUFER_CHANGE ends at 1.

Source files
------------

// File: rtl/adc_line_sequencer.sv
// adc_line_sequencer: per-pixel ADC strobe generation, result realignment,
// and line/frame sequencing for one detector channel feeding a ping-pong line buffer.
//
// Ports:
//   CLK          system clock, all logic on the rising edge
//   RESET_N      synchronous active-low reset
//   FRAME_START  one-cycle frame request, honoured only while idle
//   ADC_DATA     pipelined ADC conversion result
//   ADC_CONVST   conversion strobe, one pixel per high cycle
//   DATA_OUT     realigned sample to the line buffer
//   BUFER_IN_EN  DATA_OUT valid / buffer write enable
//   BUFER_CHANGE buffer bank select, toggles at every completed line
//   LINE_DONE    one-cycle pulse after the last write of a line
//   FRAME_DONE   one-cycle pulse with the last LINE_DONE of a frame
//   BUSY         high whenever a frame is in progress
//   ROW_CNT      index of the line being acquired
module adc_line_sequencer #(
    parameter int ADC_WIDTH    = 14,
    parameter int PIX_PER_LINE = 320,
    parameter int ROWS         = 240,
    parameter int ADC_LATENCY  = 3,
    parameter int LINE_BLANK   = 16,
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 FRAME_START,
    input  logic [ADC_WIDTH-1:0] ADC_DATA,
    output logic                 ADC_CONVST,
    output logic [ADC_WIDTH-1:0] DATA_OUT,
    output logic                 BUFER_IN_EN,
    output logic                 BUFER_CHANGE,
    output logic                 LINE_DONE,
    output logic                 FRAME_DONE,
    output logic                 BUSY,
    output logic [ROW_W-1:0]     ROW_CNT
);

    localparam int PIX_W = (PIX_PER_LINE > 1) ? $clog2(PIX_PER_LINE) : 1;
    localparam int BLK_W = 8;

    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_PER_LINE - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(LINE_BLANK - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LINE,
        FLUSH,
        BLANK
    } state_t;

    state_t                 state;
    logic [PIX_W-1:0]       pix_left;
    logic [BLK_W-1:0]       blank_left;
    // One bit per conversion in flight; the top bit marks the cycle in
    // which ADC_DATA carries the result of the strobe ADC_LATENCY ago.
    logic [ADC_LATENCY-1:0] vld;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state        <= IDLE;
            pix_left     <= '0;
            blank_left   <= '0;
            vld          <= '0;
            ADC_CONVST   <= 1'b0;
            DATA_OUT     <= '0;
            BUFER_IN_EN  <= 1'b0;
            BUFER_CHANGE <= 1'b0;
            LINE_DONE    <= 1'b0;
            FRAME_DONE   <= 1'b0;
            BUSY         <= 1'b0;
            ROW_CNT      <= '0;
        end else begin
            // The pipe runs in every state so samples still in flight when
            // the strobes stop are drained during FLUSH.
            vld         <= ADC_LATENCY'({vld, ADC_CONVST});
            BUFER_IN_EN <= vld[ADC_LATENCY-1];
            if (vld[ADC_LATENCY-1]) begin
                DATA_OUT <= ADC_DATA;
            end

            LINE_DONE  <= 1'b0;
            FRAME_DONE <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (FRAME_START) begin
                        state      <= LINE;
                        ADC_CONVST <= 1'b1;
                        pix_left   <= PIX_LAST;
                        ROW_CNT    <= '0;
                        BUSY       <= 1'b1;
                    end
                end

                LINE: begin
                    if (pix_left == '0) begin
                        ADC_CONVST <= 1'b0;
                        state      <= FLUSH;
                    end else begin
                        pix_left <= pix_left - 1'b1;
                    end
                end

                FLUSH: begin
                    // A LINE_DONE seen here belongs to the last line of the
                    // frame: that pulse cycle still counts as busy.
                    if (LINE_DONE) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end else if (BUFER_IN_EN && (vld == '0)) begin
                        LINE_DONE    <= 1'b1;
                        BUFER_CHANGE <= ~BUFER_CHANGE;
                        if (ROW_CNT == ROW_LAST) begin
                            FRAME_DONE <= 1'b1;
                        end else begin
                            ROW_CNT    <= ROW_CNT + 1'b1;
                            blank_left <= BLK_LAST;
                            state      <= BLANK;
                        end
                    end
                end

                BLANK: begin
                    // The LINE_DONE cycle is the first blanking cycle.
                    if (blank_left == '0) begin
                        state      <= LINE;
                        ADC_CONVST <= 1'b1;
                        pix_left   <= PIX_LAST;
                    end else begin
                        blank_left <= blank_left - 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_line_sequencer.sv
// Bench for adc_line_sequencer: two configurations, table-driven timing checks
// and a queue scoreboard matching each conversion to its buffer write.
module tb_adc_line_sequencer;

    localparam int W = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function void chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // DUT A: PIX 4, LAT 2, BLANK 3, ROWS 2
    logic         a_rst_n = 1'b0;
    logic         a_start = 1'b0;
    logic [W-1:0] a_adc   = 14'h3FFF;
    logic         a_convst, a_en, a_bchg, a_ld, a_fd, a_busy;
    logic [W-1:0] a_dout;
    logic [0:0]   a_row;

    adc_line_sequencer #(
        .ADC_WIDTH(W), .PIX_PER_LINE(4), .ROWS(2),
        .ADC_LATENCY(2), .LINE_BLANK(3)
    ) dut_a (
        .CLK(clk), .RESET_N(a_rst_n), .FRAME_START(a_start),
        .ADC_DATA(a_adc), .ADC_CONVST(a_convst), .DATA_OUT(a_dout),
        .BUFER_IN_EN(a_en), .BUFER_CHANGE(a_bchg), .LINE_DONE(a_ld),
        .FRAME_DONE(a_fd), .BUSY(a_busy), .ROW_CNT(a_row)
    );

    // DUT B: PIX 1, LAT 1, BLANK 1, ROWS 3
    logic         b_rst_n = 1'b0;
    logic         b_start = 1'b0;
    logic [W-1:0] b_adc   = 14'h3FFF;
    logic         b_convst, b_en, b_bchg, b_ld, b_fd, b_busy;
    logic [W-1:0] b_dout;
    logic [1:0]   b_row;

    adc_line_sequencer #(
        .ADC_WIDTH(W), .PIX_PER_LINE(1), .ROWS(3),
        .ADC_LATENCY(1), .LINE_BLANK(1)
    ) dut_b (
        .CLK(clk), .RESET_N(b_rst_n), .FRAME_START(b_start),
        .ADC_DATA(b_adc), .ADC_CONVST(b_convst), .DATA_OUT(b_dout),
        .BUFER_IN_EN(b_en), .BUFER_CHANGE(b_bchg), .LINE_DONE(b_ld),
        .FRAME_DONE(b_fd), .BUSY(b_busy), .ROW_CNT(b_row)
    );

    // ADC model + scoreboard for A (runs at #1 after each edge)
    logic [W-1:0] a_q[$];
    int a_pend[int];
    int a_k = 0, a_cyc = 0;
    int a_en_cnt = 0, a_ld_cnt = 0, a_fd_cnt = 0;

    initial forever begin
        @(posedge clk);
        #1;
        a_cyc++;
        if (!a_rst_n) begin
            a_q.delete();
            a_pend.delete();
            a_k   = 0;
            a_adc = 14'h3FFF;
        end else begin
            if (a_convst === 1'b1) begin
                a_pend[a_cyc + 2] = 100 + a_k;
                a_q.push_back(W'(100 + a_k));
                a_k++;
            end
            if (a_en === 1'b1) begin
                a_en_cnt++;
                if (a_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_data: unexpected write %0d", a_dout);
                end else begin
                    chk("a_data", 32'(a_dout), 32'(a_q.pop_front()));
                end
            end
            if (a_ld === 1'b1) a_ld_cnt++;
            if (a_fd === 1'b1) a_fd_cnt++;
            if (a_pend.exists(a_cyc)) begin
                a_adc = W'(a_pend[a_cyc]);
                a_pend.delete(a_cyc);
            end else begin
                a_adc = W'($urandom);
            end
        end
    end

    // ADC model + scoreboard for B
    logic [W-1:0] b_q[$];
    int b_pend[int];
    int b_k = 0, b_cyc = 0;
    int b_en_cnt = 0, b_ld_cnt = 0, b_fd_cnt = 0;

    initial forever begin
        @(posedge clk);
        #1;
        b_cyc++;
        if (!b_rst_n) begin
            b_q.delete();
            b_pend.delete();
            b_k   = 0;
            b_adc = 14'h3FFF;
        end else begin
            if (b_convst === 1'b1) begin
                b_pend[b_cyc + 1] = 100 + b_k;
                b_q.push_back(W'(100 + b_k));
                b_k++;
            end
            if (b_en === 1'b1) begin
                b_en_cnt++;
                if (b_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_data: unexpected write %0d", b_dout);
                end else begin
                    chk("b_data", 32'(b_dout), 32'(b_q.pop_front()));
                end
            end
            if (b_ld === 1'b1) b_ld_cnt++;
            if (b_fd === 1'b1) b_fd_cnt++;
            if (b_pend.exists(b_cyc)) begin
                b_adc = W'(b_pend[b_cyc]);
                b_pend.delete(b_cyc);
            end else begin
                b_adc = W'($urandom);
            end
        end
    end

    // Expected per-cycle flags for A: {busy,convst,en,ld,fd,bchg}
    typedef struct {
        int         cyc;
        logic [5:0] flg;
        int         row;
    } vec_t;

    vec_t tbl[25];
    int   starts_q[$];

    function bit is_start(input int c);
        foreach (starts_q[i]) if (starts_q[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset_a();
        a_rst_n = 1'b0;
        a_start = 1'b0;
        tick();
        tick();
        a_rst_n = 1'b1;
    endtask

    task automatic run_a(input int nchk, input int last, input int rst_at);
        a_en_cnt = 0;
        a_ld_cnt = 0;
        a_fd_cnt = 0;
        for (int c = 0; c <= last; c++) begin
            if (c < nchk) begin
                chk($sformatf("a_flags c%0d", tbl[c].cyc),
                    {a_busy, a_convst, a_en, a_ld, a_fd, a_bchg}, tbl[c].flg);
                if (tbl[c].row >= 0)
                    chk($sformatf("a_row c%0d", c), a_row, tbl[c].row);
            end
            if (rst_at >= 0 && c > rst_at) begin
                chk($sformatf("a_postrst c%0d", c),
                    {a_en, a_bchg, a_ld, a_busy, a_convst, a_row}, 0);
            end
            a_start = is_start(c);
            a_rst_n = (c != rst_at);
            tick();
        end
        a_start = 1'b0;
        a_rst_n = 1'b1;
    endtask

    task automatic run_b(input int last);
        int  p, nld;
        bit  act;
        logic [5:0] e;
        b_en_cnt = 0;
        b_ld_cnt = 0;
        b_fd_cnt = 0;
        for (int c = 0; c <= last; c++) begin
            p   = c - 1;
            act = (c >= 1) && (c <= 12);
            nld = (c >= 4) ? (((c > 12) ? 12 : c) / 4) : 0;
            e = {act,
                 act && (p % 4 == 0),
                 act && (p % 4 == 2),
                 act && (p % 4 == 3),
                 c == 12,
                 nld[0]};
            chk($sformatf("b_flags c%0d", c),
                {b_busy, b_convst, b_en, b_ld, b_fd, b_bchg}, e);
            if (act && (p % 4 == 0))
                chk($sformatf("b_row c%0d", c), b_row, p / 4);
            b_start = (c == 0);
            tick();
        end
        b_start = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{0,  6'b000000, 0};
        tbl[1]  = '{1,  6'b110000, 0};
        tbl[2]  = '{2,  6'b110000, 0};
        tbl[3]  = '{3,  6'b110000, 0};
        tbl[4]  = '{4,  6'b111000, 0};
        tbl[5]  = '{5,  6'b101000, 0};
        tbl[6]  = '{6,  6'b101000, 0};
        tbl[7]  = '{7,  6'b101000, 0};
        tbl[8]  = '{8,  6'b100101, -1};
        tbl[9]  = '{9,  6'b100001, 1};
        tbl[10] = '{10, 6'b100001, 1};
        tbl[11] = '{11, 6'b110001, 1};
        tbl[12] = '{12, 6'b110001, 1};
        tbl[13] = '{13, 6'b110001, 1};
        tbl[14] = '{14, 6'b111001, 1};
        tbl[15] = '{15, 6'b101001, 1};
        tbl[16] = '{16, 6'b101001, 1};
        tbl[17] = '{17, 6'b101001, 1};
        tbl[18] = '{18, 6'b100110, -1};
        tbl[19] = '{19, 6'b000000, -1};
        tbl[20] = '{20, 6'b110000, 0};
        tbl[21] = '{21, 6'b110000, 0};
        tbl[22] = '{22, 6'b110000, 0};
        tbl[23] = '{23, 6'b111000, 0};
        tbl[24] = '{24, 6'b101000, 0};

        // Reset held 3 cycles with FRAME_START and ADC_DATA all-ones
        a_rst_n = 1'b0;
        a_start = 1'b1;
        b_rst_n = 1'b0;
        b_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_a", {a_convst, a_en, a_bchg, a_ld, a_fd, a_busy,
                            a_row, a_dout}, 0);
            chk("reset_b", {b_convst, b_en, b_bchg, b_ld, b_fd, b_busy,
                            b_row, b_dout}, 0);
        end
        a_rst_n = 1'b1;
        a_start = 1'b0;
        b_rst_n = 1'b1;
        b_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_a", {a_busy, a_convst, a_en, a_ld}, 0);
            chk("idle_b", {b_busy, b_convst, b_en, b_ld}, 0);
        end

        // Latency/alignment, then back-to-back frame at cycle 19
        starts_q = '{0, 19};
        run_a(25, 24, -1);

        // Ignored FRAME_START pulses inside a frame
        do_reset_a();
        starts_q = '{0, 2, 9, 15};
        run_a(19, 30, -1);
        chk("ign_en_cnt", a_en_cnt, 8);
        chk("ign_fd_cnt", a_fd_cnt, 1);
        chk("ign_ld_cnt", a_ld_cnt, 2);
        chk("ign_q_empty", a_q.size(), 0);
        chk("ign_busy", a_busy, 0);

        // Reset in the middle of the second line
        do_reset_a();
        starts_q = '{0};
        run_a(13, 24, 13);
        chk("mid_ld_cnt", a_ld_cnt, 1);
        chk("mid_fd_cnt", a_fd_cnt, 0);

        // Minimum-parameter corner on DUT B
        run_b(16);
        chk("b_en_cnt", b_en_cnt, 3);
        chk("b_ld_cnt", b_ld_cnt, 3);
        chk("b_fd_cnt", b_fd_cnt, 1);
        chk("b_bchg_end", b_bchg, 1);
        chk("b_q_empty", b_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
